// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host link: FSM encoding, default timings and
// the keyboard command bytes used by the controllers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SETUP,
    SHIFT,
    ACK,
    RECOVER
  } ps2_tx_state_e;

  // 100 us inhibit, 5 us setup and 20 ms edge watchdog at 100 MHz
  localparam int unsigned INHIBIT_CYCLES_DEF = 10000;
  localparam int unsigned SETUP_CYCLES_DEF   = 500;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and completion status between a controller and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a falling-edge strobe on the
// synchronized level. Flops reset high to match an idle, pulled-up bus.
module ps2_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  output logic level,
  output logic fall
);

  // sync[0], sync[1]: synchronizer stages; sync[2]: previous synchronized value
  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (!rstn) sync <= 3'b111;
    else       sync <= {sync[1:0], pin};
  end

  assign level = sync[1];
  assign fall  = sync[2] & ~sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one command
// frame on the device clock, then check the device ACK.
//
// state   | meaning
// IDLE    | lines released, ready for a command byte
// INHIBIT | clock held low
// SETUP   | clock and data held low (start bit)
// SHIFT   | clock released, data/parity/stop driven on device falls
// ACK     | waiting for the device to pull data low on the 11th fall
// RECOVER | waiting for both lines to return high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned SETUP_CYCLES   = SETUP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned DUR_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DUR_W = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DUR_W-1:0] INH_LOAD = DUR_W'(INHIBIT_CYCLES - 1);
  localparam logic [DUR_W-1:0] SET_LOAD = DUR_W'(SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state, state_nxt;
  logic [9:0]       sr, sr_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [DUR_W-1:0] dur_cnt, dur_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic             clk_oe_nxt, data_oe_nxt;
  logic             done_q, done_nxt, err_q, err_nxt;
  logic             clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic             in_frame;

  ps2_sync_edge u_sync_clk (
    .clk   (clk),
    .rstn  (rstn),
    .pin   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (clk),
    .rstn  (rstn),
    .pin   (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  assign tx.tx_ready = (state == IDLE);
  assign tx.busy     = (state != IDLE);
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;
  assign in_frame    = (state == SHIFT) || (state == ACK) || (state == RECOVER);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      dur_cnt     <= '0;
      wd_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      bit_cnt     <= bit_cnt_nxt;
      dur_cnt     <= dur_nxt;
      wd_cnt      <= wd_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    dur_nxt     = dur_cnt;
    wd_nxt      = '0;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    if (in_frame && !clk_fall) wd_nxt = wd_cnt + 1'b1;

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx.tx_valid) begin
          sr_nxt      = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          bit_cnt_nxt = '0;
          dur_nxt     = INH_LOAD;
          clk_oe_nxt  = 1'b1;
          state_nxt   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (dur_cnt == '0) begin
          dur_nxt     = SET_LOAD;
          data_oe_nxt = 1'b1;
          state_nxt   = SETUP;
        end else begin
          dur_nxt = dur_cnt - 1'b1;
        end
      end
      SETUP: begin
        if (dur_cnt == '0) begin
          clk_oe_nxt = 1'b0;
          state_nxt  = SHIFT;
        end else begin
          dur_nxt = dur_cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          data_oe_nxt = ~sr[0];
          sr_nxt      = {1'b0, sr[9:1]};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_nxt = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (data_lvl) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (clk_lvl && data_lvl) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // device stopped clocking: abandon the frame unless it just finished
    if (in_frame && !clk_fall && (wd_cnt == WD_LAST) && (state_nxt != IDLE)) begin
      err_nxt     = 1'b1;
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      wd_nxt      = '0;
      state_nxt   = IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on the bus, a scoreboard of
// expected frame outcomes and directed timing checks, with shortened timings.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 200;
  localparam int SET = 40;
  localparam int TO  = 1000;
  localparam int H   = 30;   // device clock half period in system cycles

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if bus ();

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx          (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          chk_frame;
    logic [7:0]  data;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          dev_mode = 0;   // 0 ACK, 1 no ACK, 2 silent, 3 stop after 4 falls
  bit          dev_stopped = 1'b0;
  logic [10:0] dev_frame = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bus bits as a device sees them: start, data LSB first, odd parity, stop
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b, input bit push, input bit err, input bit chk_frame);
    bit ok = 1'b0;
    exp_t e;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", 32'(ok), 32'd1);
    if (push) begin
      e.err = err; e.chk_frame = chk_frame; e.data = b; e.frame = ref_frame(b);
      exp_q.push_back(e);
    end
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
    repeat (2 * H) @(negedge clk);
  endtask

  // PS/2 device model
  initial begin : device
    forever begin : dev_loop
      int          mode;
      bit          ok;
      logic [10:0] cap;
      wait (ps2_clk_oe === 1'b1);
      mode = dev_mode;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (ps2_clk_in === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      chk("dev_release", 32'(ok), 32'd1);
      if (ok && mode != 2) begin
        cap = '0;
        cap[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
          if (mode == 3 && i == 5) break;
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b0;
          cap[i] = ps2_data_in;
        end
        if (mode == 3) begin
          dev_stopped = 1'b1;
        end else begin
          dev_frame = cap;
          repeat (H) @(negedge clk);
          if (mode == 0) dev_data_low = 1'b1;
          repeat (2) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (2) @(negedge clk);
          dev_data_low = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    bit was_pulse = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (was_pulse) chk("pulse_width", 32'({bus.tx_done, bus.tx_err}), 32'd0);
      was_pulse = 1'b0;
      if (rstn && (bus.tx_done || bus.tx_err)) begin
        was_pulse = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({bus.tx_done, bus.tx_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("done_%02h", e.data), 32'(bus.tx_done), 32'(!e.err));
          chk($sformatf("err_%02h", e.data), 32'(bus.tx_err), 32'(e.err));
          chk("oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          chk("ready_at_end", 32'({bus.tx_ready, bus.busy}), 32'b10);
          if (e.chk_frame) chk($sformatf("frame_%02h", e.data), 32'(dev_frame), 32'(e.frame));
        end
      end
    end
  end

  initial begin : stim
    int   clk_hi, d_rise, fall_k, err_k;
    logic clk_after;
    bit   ok;
    logic [7:0] b;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulses", 32'({bus.tx_done, bus.tx_err}), 32'd0);
    rstn = 1'b1;

    // frame content and inhibit/setup timing
    dev_mode = 0;
    send(CMD_SET_LED, 1'b1, 1'b0, 1'b1);
    clk_hi = 0; d_rise = 0; clk_after = 1'b1;
    for (int k = 1; k <= INH + SET + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= INH + SET && ps2_clk_oe) clk_hi++;
      if (d_rise == 0 && ps2_data_oe) d_rise = k;
      if (k == INH + SET + 1) clk_after = ps2_clk_oe;
    end
    chk("clk_oe_high_cycles", clk_hi, INH + SET);
    chk("data_oe_rise_cycle", d_rise, INH + 1);
    chk("clk_oe_released", 32'(clk_after), 32'd0);
    wait_idle();

    // missing ACK
    dev_mode = 1;
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // device never clocks
    dev_mode = 2;
    send(8'h12, 1'b1, 1'b1, 1'b0);
    fall_k = -1; err_k = -1;
    for (int k = 1; k <= INH + SET + TO + 50; k++) begin
      if (k > 1) @(negedge clk);
      if (fall_k < 0 && !ps2_clk_oe) fall_k = k;
      if (bus.tx_err) begin
        err_k = k;
        break;
      end
    end
    chk("timeout_cycles", err_k - fall_k, TO);
    wait_idle();

    // reset mid-frame
    dev_mode = 3;
    dev_stopped = 1'b0;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dev_stopped) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dev_stop_wait", 32'(ok), 32'd1);
    dev_mode = 0;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("midrst_ready", 32'(bus.tx_ready), 32'd1);
    chk("midrst_pulses", 32'({bus.tx_done, bus.tx_err}), 32'd0);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    send(CMD_RESET, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // busy rejection
    send(8'hC3, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("reject_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_idle();

    // back-to-back commands and random bytes
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      b = CMD_ENABLE;
      else if (i == 1) b = CMD_SET_LED;
      else             b = 8'($urandom_range(0, 255));
      send(b, 1'b1, 1'b0, 1'b1);
    end
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending end of the keyboard link whose receive side already feeds the chess top level. It accepts one command byte per handshake, inhibits the bus, issues a request-to-send, and shifts start, data, parity and stop bits on the keyboard-generated clock. It then checks the device ACK and reports done or error. Typical uses are LED control (0xED + mask), reset (0xFF) and enable (0xF4). The PS/2 pins are driven open-drain through a top-level tristate.

## Interface
- INHIBIT_CYCLES, 10000: cycles the host holds the PS/2 clock low (100 µs at 100 MHz).
- SETUP_CYCLES, 500: cycles the host holds both lines low before releasing the clock (5 µs).
- TIMEOUT_CYCLES, 2000000: maximum gap allowed between device clock falling edges, and from request to the first edge (20 ms).
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  reset, synchronous, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  byte offered.
- tx_ready  out  1  block idle; accepts a byte when tx_valid is high.
- ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data_in  in  1  raw PS/2 data pin, asynchronous.
- ps2_clk_oe  out  1  1 drives the clock pin low; 0 releases it.
- ps2_data_oe  out  1  1 drives the data pin low; 0 releases it.
- busy  out  1  equals !tx_ready; the receiver discards frames while this is high.
- tx_done  out  1  one-cycle pulse when the frame completes with a valid ACK.
- tx_err  out  1  one-cycle pulse on a missing ACK or a timeout.

## Operation
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. A falling edge `fall` is detected on the synchronized clock, comparing it with its previous value.
- The state machine states are IDLE, INHIBIT, SETUP, SHIFT, ACK, RECOVER.
- **IDLE**
  - Both oe outputs are 0 and tx_ready is 1.
  - When tx_valid and tx_ready are both high, the block latches the shift register as {stop=1, parity=~^tx_data, tx_data}. It clears the bit counter and goes to INHIBIT.
- **INHIBIT**
  - clk_oe is 1 and data_oe is 0.
  - After INHIBIT_CYCLES cycles the block goes to SETUP.
- **SETUP**
  - clk_oe is 1 and data_oe is 1; this is the start bit.
  - After SETUP_CYCLES cycles the block goes to SHIFT with clk_oe at 0.
- **SHIFT**
  - On each `fall`, data_oe is set to the inverse of the current LSB, the register shifts right, and the bit counter increments.
  - Falls 1–8 carry data bits LSB first, fall 9 carries parity, and fall 10 carries the stop bit (data_oe=0).
  - After fall 10 the block goes to ACK.
- **ACK**
  - On `fall`, the block samples the synchronized data line. A value of 0 goes to RECOVER; a value of 1 pulses tx_err and goes to IDLE.
- **RECOVER**
  - The block waits until the synchronized clock and data are both 1.
  - It then pulses tx_done and goes to IDLE.
- A watchdog counter clears on every `fall` and on entry to SHIFT. In SHIFT, ACK or RECOVER, reaching TIMEOUT_CYCLES pulses tx_err, releases both lines and returns to IDLE.
- tx_valid is ignored whenever the block is not in IDLE, and there is no queue.
- Parity is odd.
- Bit counter width is 4 bits. The duration counters use $clog2 of the larger of their parameters.

## Timing
- Reset values: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, and all counters 0.
  - tx_ready is decoded from the state, so it reads 1 while in reset.
- rstn low at any clock edge, including mid-frame, releases both lines at that edge; there is no pending done or err pulse.
- All outputs are registered except tx_ready and busy.
- A handshake at edge N produces ps2_clk_oe=1 from N+1.
- clk_oe stays high for exactly INHIBIT_CYCLES+SETUP_CYCLES cycles.
- data_oe rises at cycle N+1+INHIBIT_CYCLES.
- A pin falling edge reaches data_oe 3 cycles later: 2 synchronizer stages plus the registered update. This is well inside the device's clock-low half period of at least 30 µs.
- tx_done or tx_err asserts for exactly one cycle, coincident with the return to IDLE.
- Back-to-back transfers are allowed: the handshake may occur in the first IDLE cycle after a done or err pulse.

## Structure
- ps2_pkg holds:
  - the state enum;
  - default INHIBIT, SETUP and TIMEOUT values;
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, and ACK byte 8'hFA.
- Sub-module ps2_sync_edge is the 2-flop synchronizer plus falling-edge detector. It has one instance per line here and is reusable by the receiver.

## Test plan
- **Frame content:** send 0xED to a device model that clocks at 12 kHz and ACKs.
  - Bus data sampled at each device rising edge must read 0,1,0,1,1,0,1,1,1,1(parity),1(stop).
  - The device ACK must be seen, then tx_done pulses once and tx_ready returns to 1.
- **Inhibit and setup timing:** handshake at cycle 0.
  - clk_oe must be high over cycles 1–10500.
  - data_oe must rise at cycle 10001.
  - clk_oe must be 0 at cycle 10501.
- **Missing ACK:** the device model leaves data high at the 11th falling edge.
  - tx_err pulses one cycle, tx_done stays 0, and both oe outputs are 0.
- **Timeout:** the device never clocks after the request.
  - tx_err must pulse exactly TIMEOUT_CYCLES cycles after SHIFT entry, with both lines released.
- **Reset mid-frame:** assert rstn low after data bit 3.
  - Both oe outputs must be 0 at the next edge, tx_ready=1, and no done or err pulse.
  - A new 0xFF is then sent correctly.
- **Busy rejection:** pulse tx_valid with 0x55 during INHIBIT.
  - The frame in flight keeps its original byte and 0x55 is never transmitted.
